// File: rtl/cpu_pkg.sv
// cpu_pkg: encodings shared by the fetch sequencer and the control unit.
//   - stage_e        : 3-bit pipeline-stage encoding (IF..WB)
//   - PC_SRC_* / J_SRC_* : PC selection codes driven by the control unit
//   - instruction field positions (opcode, 14-bit branch offset, 26-bit jump target)
package cpu_pkg;

    typedef enum logic [2:0] {
        IF_STAGE  = 3'b000,
        ID_STAGE  = 3'b001,
        EX_STAGE  = 3'b010,
        MEM_STAGE = 3'b011,
        WB_STAGE  = 3'b100
    } stage_e;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

    localparam logic J_SRC_TARGET = 1'b0;
    localparam logic J_SRC_RETURN = 1'b1;

    localparam int OPC_MSB     = 31;
    localparam int OPC_LSB     = 26;
    localparam int IMM14_MSB   = 13;
    localparam int IMM14_LSB   = 0;
    localparam int JTARG26_MSB = 25;
    localparam int JTARG26_LSB = 0;

    // Encodings 101..111 do not name a stage.
    function automatic logic is_legal_stage(input logic [2:0] s);
        return (s <= 3'b100);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular LIFO of return addresses.
//   push/pop      : operation strobes (both together = replace top, return old top)
//   push_data     : address to push
//   pop_data      : current top, or RESET_PC when empty
//   full/empty    : occupancy flags
//   err           : one-cycle pulse on push-when-full or pop-when-empty
// A push into a full stack overwrites the oldest entry, so the newest
// RAS_DEPTH return addresses are always retained.
module return_addr_stack
    import cpu_pkg::*;
#(
    parameter int                RAS_DEPTH = 8,
    parameter int                PC_W      = 32,
    parameter logic [PC_W-1:0]   RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] pop_data,
    output logic            full,
    output logic            empty,
    output logic            err
);

    localparam int               PTR_W   = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    logic [PC_W-1:0]  mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] top_r;     // next write slot; top entry lives at top_r-1
    logic [PTR_W:0]   cnt_r;     // valid entries, saturates at RAS_DEPTH
    logic [PTR_W-1:0] top_m1_s;

    // Occupancy, top-of-stack read and error pulse.
    always_comb begin
        top_m1_s = top_r - PTR_ONE;
        full     = (cnt_r == DEPTH_C);
        empty    = (cnt_r == '0);
        if (empty) begin
            pop_data = RESET_PC;
        end else begin
            pop_data = mem_r[top_m1_s];
        end
        err = (push && !pop && full) || (pop && !push && empty);
    end

    // Storage, pointer and occupancy update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_r <= '0;
            cnt_r <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push && pop) begin
            mem_r[top_m1_s] <= push_data;
        end else if (push) begin
            mem_r[top_r] <= push_data;
            top_r        <= top_r + PTR_ONE;
            if (!full) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else if (pop) begin
            if (!empty) begin
                top_r <= top_m1_s;
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: owns PC, IR and stage register of the multi-cycle CPU.
//   clk, rst_n            : clock, async active-low reset
//   pc_src, j_src, is_call, next_state : decisions from the control unit
//   imem_req/addr/valid/rdata : instruction-memory request/valid handshake
//   state, opcode, instr, pc  : current stage, IR fields and PC to the control unit
//   illegal_state, ras_err    : sticky fault flags, cleared only by reset
// The PC changes only on commit (leaving a non-IF stage for IF) or when an
// illegal next_state forces a return to IF.
module instr_fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter int              INSTR_W   = 32,
    parameter int              RAS_DEPTH = 8,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         pc_src,
    input  logic               j_src,
    input  logic               is_call,
    input  logic [2:0]         next_state,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [2:0]         state,
    output logic [5:0]         opcode,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic               illegal_state,
    output logic               ras_err
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam int              IMM_W  = IMM14_MSB - IMM14_LSB + 1;

    stage_e             state_r, state_s;
    logic               req_r, req_s;
    logic [INSTR_W-1:0] ir_r, ir_s;
    logic [PC_W-1:0]    pc_r, pc_s;
    logic               illegal_r, illegal_s;
    logic               ras_err_r, ras_err_s;

    logic               accept_s;
    logic               advance_s;
    logic               legal_s;
    logic               commit_s;
    logic               push_s;
    logic               pop_s;
    logic [PC_W-1:0]    pc_inc_s;
    logic [PC_W-1:0]    pc_commit_s;
    logic [PC_W-1:0]    ras_top_s;
    logic               ras_full_s;
    logic               ras_empty_s;
    logic               ras_err_pulse_s;

    return_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W),
        .RESET_PC  (RESET_PC)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_inc_s),
        .pop_data  (ras_top_s),
        .full      (ras_full_s),
        .empty     (ras_empty_s),
        .err       (ras_err_pulse_s)
    );

    // Handshake and commit qualification.
    always_comb begin
        accept_s  = req_r && imem_valid;
        legal_s   = is_legal_stage(next_state);
        // IF waits for the fetched word; every other stage moves each cycle.
        advance_s = (state_r != IF_STAGE) || accept_s;
        commit_s  = (state_r != IF_STAGE) && legal_s && (next_state == IF_STAGE);
        push_s    = commit_s && is_call;
        pop_s     = commit_s && (pc_src == PC_SRC_JUMP) && (j_src == J_SRC_RETURN);
        pc_inc_s  = pc_r + PC_ONE;
    end

    // PC value selected by the control unit for a commit.
    always_comb begin
        pc_commit_s = pc_r;
        case (pc_src)
            PC_SRC_SEQ:    pc_commit_s = pc_inc_s;
            PC_SRC_BRANCH: pc_commit_s = pc_r + {{(PC_W-IMM_W){ir_r[IMM14_MSB]}},
                                                 ir_r[IMM14_MSB:IMM14_LSB]};
            PC_SRC_JUMP: begin
                if (j_src == J_SRC_RETURN) begin
                    pc_commit_s = ras_top_s;
                end else begin
                    pc_commit_s = {pc_r[PC_W-1:JTARG26_MSB+1], ir_r[JTARG26_MSB:JTARG26_LSB]};
                end
            end
            PC_SRC_HOLD:   pc_commit_s = pc_r;
            default:       pc_commit_s = pc_r;
        endcase
    end

    // Next stage, IR, PC, request and sticky flags.
    always_comb begin
        state_s   = state_r;
        ir_s      = ir_r;
        pc_s      = pc_r;
        illegal_s = illegal_r;
        ras_err_s = ras_err_r || ras_err_pulse_s;

        if (accept_s) begin
            ir_s = imem_rdata;
        end else begin
            ir_s = ir_r;
        end

        if (advance_s) begin
            if (legal_s) begin
                state_s = stage_e'(next_state);
                if (commit_s) begin
                    pc_s = pc_commit_s;
                end else begin
                    pc_s = pc_r;
                end
            end else begin
                // Abandon the instruction; skip it if it had been fetched.
                state_s   = IF_STAGE;
                illegal_s = 1'b1;
                if (state_r != IF_STAGE) begin
                    pc_s = pc_inc_s;
                end else begin
                    pc_s = pc_r;
                end
            end
        end else begin
            state_s = state_r;
        end

        // Entering (or staying in) IF raises the request on the same edge.
        req_s = (state_s == IF_STAGE) && !accept_s;
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IF_STAGE;
            req_r     <= 1'b0;
            ir_r      <= '0;
            pc_r      <= RESET_PC;
            illegal_r <= 1'b0;
            ras_err_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            req_r     <= req_s;
            ir_r      <= ir_s;
            pc_r      <= pc_s;
            illegal_r <= illegal_s;
            ras_err_r <= ras_err_s;
        end
    end

    assign imem_req      = req_r;
    assign imem_addr     = pc_r;
    assign state         = state_r;
    assign opcode        = ir_r[OPC_MSB:OPC_LSB];
    assign instr         = ir_r;
    assign pc            = pc_r;
    assign illegal_state = illegal_r;
    assign ras_err       = ras_err_r;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed self-checking bench for instr_fetch_sequencer. The bench plays
// both instruction memory and control unit.
module tb_instr_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_src;
    logic        j_src;
    logic        is_call;
    logic [2:0]  next_state;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [2:0]  state;
    logic [5:0]  opcode;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        illegal_state;
    logic        ras_err;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_sequencer #(
        .PC_W(32), .INSTR_W(32), .RAS_DEPTH(8), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .j_src(j_src),
        .is_call(is_call), .next_state(next_state), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .state(state), .opcode(opcode), .instr(instr), .pc(pc),
        .illegal_state(illegal_state), .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, then return word; stage moves to ns.
    task automatic do_fetch(input logic [31:0] word, input logic [2:0] ns);
        next_state = ns;
        for (int k = 0; k < 10 && !imem_req; k++) step();
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_timeout: imem_req=%0b required 1", imem_req);
        end
        imem_valid = 1'b1;
        imem_rdata = word;
        step();
        imem_valid = 1'b0;
    endtask

    task automatic commit(input logic [1:0] src, input logic js, input logic call);
        next_state = 3'b000;
        pc_src     = src;
        j_src      = js;
        is_call    = call;
        step();
        pc_src     = 2'b11;
        j_src      = 1'b0;
        is_call    = 1'b0;
        next_state = 3'b001;
    endtask

    task automatic jump_to(input logic [31:0] target);
        do_fetch({6'h02, target[25:0]}, 3'b001);
        commit(2'b10, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({pc, state, imem_req, instr, illegal_state, ras_err} !== {32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: pc=%h state=%b req=%b ir=%h ill=%b rerr=%b required all zero",
                     pc, state, imem_req, instr, illegal_state, ras_err);
        end
        #10 rst_n = 1'b1;   // released between edges
        step();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: req=%b addr=%h required 1/0", imem_req, imem_addr);
        end
        imem_valid = 1'b1;
        imem_rdata = 32'h0C000000;
        next_state = 3'b001;
        step();
        imem_valid = 1'b0;
        n_checks++;
        if (instr !== 32'h0C000000 || opcode !== 6'b000011 || state !== 3'b001 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_fetch: ir=%h opc=%b state=%b req=%b required 0c000000/000011/001/0",
                     instr, opcode, state, imem_req);
        end
        commit(2'b11, 1'b0, 1'b0);
        n_checks++;
        if (pc !== 32'h0 || state !== 3'b000) begin
            n_fail++;
            $display("FAIL hold_commit: pc=%h state=%b required 0/000", pc, state);
        end
    endtask

    task automatic test_wrap;
        do_fetch({18'h0, 14'h3FFF}, 3'b001);
        commit(2'b01, 1'b0, 1'b0);
        n_checks++;
        if (pc !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL wrap_branch: pc=%h required ffffffff", pc);
        end
        do_fetch(32'h0, 3'b001);
        commit(2'b00, 1'b0, 1'b0);
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_inc: pc=%h required 00000000", pc);
        end
    endtask

    task automatic test_sequential;
        jump_to(32'h10);
        do_fetch(32'h12345678, 3'b001);
        // Valid outside a request must not disturb IR.
        imem_valid = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        step();
        imem_valid = 1'b0;
        n_checks++;
        if (instr !== 32'h12345678 || state !== 3'b001) begin
            n_fail++;
            $display("FAIL valid_ignored: ir=%h state=%b required 12345678/001", instr, state);
        end
        next_state = 3'b010;
        step();
        next_state = 3'b100;
        step();
        n_checks++;
        if (state !== 3'b100 || pc !== 32'h10) begin
            n_fail++;
            $display("FAIL seq_stages: state=%b pc=%h required 100/10", state, pc);
        end
        commit(2'b00, 1'b0, 1'b0);
        n_checks++;
        if (pc !== 32'h11 || imem_req !== 1'b1 || imem_addr !== 32'h11 || state !== 3'b000) begin
            n_fail++;
            $display("FAIL seq_commit: pc=%h req=%b addr=%h state=%b required 11/1/11/000",
                     pc, imem_req, imem_addr, state);
        end
    endtask

    task automatic test_branch;
        jump_to(32'h20);
        do_fetch({18'h0, 14'h3FFC}, 3'b001);
        commit(2'b01, 1'b0, 1'b0);
        n_checks++;
        if (pc !== 32'h1C) begin
            n_fail++;
            $display("FAIL branch_back: pc=%h required 1c", pc);
        end
    endtask

    task automatic test_call_return;
        jump_to(32'h40);
        do_fetch({6'h03, 26'h100}, 3'b001);
        commit(2'b10, 1'b0, 1'b1);
        n_checks++;
        if (pc !== 32'h100) begin
            n_fail++;
            $display("FAIL call_target: pc=%h required 100", pc);
        end
        do_fetch(32'h0, 3'b001);
        commit(2'b10, 1'b1, 1'b0);
        n_checks++;
        if (pc !== 32'h41 || ras_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ret_target: pc=%h ras_err=%b required 41/0", pc, ras_err);
        end
    endtask

    task automatic test_ras_bounds;
        logic [31:0] pushed [9];
        logic [31:0] cur;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        jump_to(32'h200);
        cur = 32'h200;
        for (int i = 0; i < 9; i++) begin
            tgt       = 32'h300 + 32'(i) * 32'h10;
            pushed[i] = cur + 32'h1;
            do_fetch({6'h03, tgt[25:0]}, 3'b001);
            commit(2'b10, 1'b0, 1'b1);
            cur = tgt;
            n_checks++;
            if (pc !== tgt) begin
                n_fail++;
                $display("FAIL call_%0d_target: pc=%h required %h", i, pc, tgt);
            end
            if (i == 7) begin
                n_checks++;
                if (ras_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ras_err_at_full: ras_err=%b required 0", ras_err);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (ras_err !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ras_overflow: ras_err=%b required 1", ras_err);
                end
            end
        end
        for (int j = 0; j < 10; j++) begin
            exp_pc = (j < 8) ? pushed[8-j] : 32'h0;
            do_fetch(32'h0, 3'b001);
            commit(2'b10, 1'b1, 1'b0);
            n_checks++;
            if (pc !== exp_pc || ras_err !== 1'b1) begin
                n_fail++;
                $display("FAIL ret_%0d: pc=%h ras_err=%b required %h/1", j, pc, ras_err, exp_pc);
            end
        end
    endtask

    task automatic test_illegal;
        jump_to(32'h50);
        do_fetch(32'h0, 3'b001);
        next_state = 3'b010;
        step();
        next_state = 3'b110;
        step();
        n_checks++;
        if (state !== 3'b000 || pc !== 32'h51 || illegal_state !== 1'b1 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_next: state=%b pc=%h ill=%b req=%b required 000/51/1/1",
                     state, pc, illegal_state, imem_req);
        end
        do_fetch(32'h0, 3'b001);
        commit(2'b00, 1'b0, 1'b0);
        n_checks++;
        if (pc !== 32'h52 || illegal_state !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_sticky: pc=%h ill=%b required 52/1", pc, illegal_state);
        end
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (illegal_state !== 1'b0 || ras_err !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flags_reset: ill=%b rerr=%b pc=%h req=%b required 0/0/0/0",
                     illegal_state, ras_err, pc, imem_req);
        end
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        pc_src     = 2'b11;
        j_src      = 1'b0;
        is_call    = 1'b0;
        next_state = 3'b001;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        test_reset();
        test_wrap();
        test_sequential();
        test_branch();
        test_call_return();
        test_ras_bounds();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
